step_ramp_gen: RTL and testbench
================================

Name: step_ramp_gen

Overview:
Upstream stage of the phase shift register. It converts a move command into one-cycle step-enable pulses and a direction level that drive the shift register's ce and down inputs. Step spacing follows a linear trapezoidal profile: accelerate, cruise, then decelerate, so the motor starts and stops without stalling. It sits between the command/host interface and the phase-pattern shift register.

Parameters:
CNT_W, 16, width of the step count and of every period/timer value
PER_MIN_LIM, 2, smallest legal period in clocks; smaller programmed values are clamped to this

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle move request; sampled only in IDLE
dir  in  1  direction, latched at accepted start; 1 = shift down
steps  in  CNT_W  number of steps in the move; 0 = no-op
per_start  in  CNT_W  clocks between steps at start and stop of the move
per_min  in  CNT_W  cruise period in clocks
per_dec  in  CNT_W  period change applied per step during ramps
step_ce  out  1  one-cycle step pulse, drives shift register ce
step_down  out  1  latched direction, drives shift register down
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse in the cycle after the final step_ce
steps_left  out  CNT_W  remaining steps in the current move

Behaviour:
- Reset (async, rst_n=0): state=IDLE; step_ce=0, step_down=0, busy=0, done=0, steps_left=0; all timers cleared. Deasserting reset mid-move abandons the move; no pulses are issued until a new start.
- IDLE: start=1 with steps!=0 latches dir, steps and the effective values; busy=1 next cycle; state becomes ACCEL.
  - Effective per_min = max(per_min, PER_MIN_LIM). Effective per_start = max(per_start, effective per_min).
  - start with steps=0: no step; done pulses next cycle; busy stays 0.
- Period timer: loads cur_per and counts down to 1; at expiry it issues step_ce for one cycle and reloads.
  - The first step_ce occurs exactly per_start clocks after the accept cycle.
- Each step_ce decrements steps_left. step_down is constant for the whole move.
- ACCEL: after each step, cur_per = max(cur_per - per_dec, per_min), saturating with no underflow. ramp_cnt increments for every step taken in ACCEL.
  - cur_per reaching per_min moves the state to CRUISE.
- CRUISE: cur_per is held.
- Deceleration entry: from ACCEL or CRUISE, when steps_left (after decrement) <= ramp_cnt, go to DECEL. This check has priority over ACCEL->CRUISE in the same cycle.
- DECEL: after each step, cur_per = min(cur_per + per_dec, per_start); ramp_cnt decrements, saturating at 0.
- Move end: the step that makes steps_left=0 ends the move. Next cycle done=1, busy=0, state=IDLE.
- A new start is accepted in the cycle after done at the earliest. start while busy is ignored.
- per_dec=0: constant-rate move at per_start; the block enters neither CRUISE nor DECEL.
- Inputs other than start are only sampled at accept; changing them mid-move has no effect.

Optional Feature:
- Macro STEP_RAMP_ABORT_EN adds input port abort (1 bit).
- With the macro: abort=1 while busy forces DECEL immediately. steps_left is set to min(steps_left, ramp_cnt), and the move ends normally with done. abort in IDLE is ignored.
- Without the macro: the port is absent; moves always run to completion.

Decomposition:
- Package step_ramp_pkg holds:
  - state enum {IDLE, ACCEL, CRUISE, DECEL}
  - default CNT_W
  - PER_MIN_LIM
  - a saturating add/sub helper function
- Sub-module step_period_timer: loadable down-counter with a one-cycle expiry pulse, instantiated once.

Test Plan:
- Constant rate: steps=4, per_start=per_min=5, per_dec=0.
  - step_ce at accept+5, +10, +15, +20; done at +21; steps_left 4->0.
- Ramp: steps=10, per_start=8, per_min=4, per_dec=2.
  - Step intervals 8,6,4,4,4,4,4,4,6,8; profile symmetric; busy high throughout.
- Short move: steps=3, per_start=10, per_min=2, per_dec=3.
  - Intervals 10,7,10 (ACCEL into DECEL, no CRUISE).
  - step_down equals the dir latched at start.
- Edge cases:
  - steps=0 -> no step_ce, single done.
  - per_min=0 -> clamped to 2.
  - start while busy -> ignored.
- Reset mid-move: rst_n low after the 3rd step_ce.
  - All outputs 0 immediately; no further step_ce after rst_n rises.
- STEP_RAMP_ABORT_EN: steps=100, abort at CRUISE with ramp_cnt=3.
  - Exactly 3 more steps at increasing period, then done.

Source files
------------

// File: rtl/step_ramp_pkg.sv
// Shared types, defaults and arithmetic helper for the step_ramp_gen block.
// Optional abort input is enabled by defining STEP_RAMP_ABORT_EN.
package step_ramp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCEL,
    CRUISE,
    DECEL
  } state_t;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_PER_MIN_LIM = 2;

  // 32-bit saturating add (sub=0) or subtract (sub=1); callers keep CNT_W below 32.
  function automatic logic [31:0] sat_addsub(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic        sub);
    if (sub) begin
      return (a > b) ? (a - b) : 32'd0;
    end
    return (a > (32'hFFFF_FFFF - b)) ? 32'hFFFF_FFFF : (a + b);
  endfunction

endpackage

// File: rtl/step_period_timer.sv
// Loadable down-counter: counts a loaded period down to 1 and flags expiry
// combinationally in that final cycle; clear stops it until the next load.
module step_period_timer
  import step_ramp_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_reg;
  logic             running_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg     <= '0;
      running_reg <= 1'b0;
    end else if (clear) begin
      cnt_reg     <= '0;
      running_reg <= 1'b0;
    end else if (load) begin
      cnt_reg     <= load_val;
      running_reg <= 1'b1;
    end else if (running_reg && (cnt_reg != ONE)) begin
      cnt_reg <= cnt_reg - ONE;
    end
  end

  assign expire = running_reg && (cnt_reg == ONE);

endmodule

// File: rtl/step_ramp_gen.sv
// Trapezoidal step pulse generator feeding the phase shift register (ce/down).
// Define STEP_RAMP_ABORT_EN to add the abort input (forced deceleration).
module step_ramp_gen
  import step_ramp_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int PER_MIN_LIM = DEF_PER_MIN_LIM
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] steps,
  input  logic [CNT_W-1:0] per_start,
  input  logic [CNT_W-1:0] per_min,
  input  logic [CNT_W-1:0] per_dec,
`ifdef STEP_RAMP_ABORT_EN
  input  logic             abort,
`endif
  output logic             step_ce,
  output logic             step_down,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] steps_left
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(PER_MIN_LIM);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cur_per_reg, cur_per_next;
  logic [CNT_W-1:0] ramp_cnt_reg, ramp_cnt_next;
  logic [CNT_W-1:0] per_start_reg, per_start_next;
  logic [CNT_W-1:0] per_min_reg, per_min_next;
  logic [CNT_W-1:0] per_dec_reg, per_dec_next;
  logic [CNT_W-1:0] steps_left_next;
  logic             busy_next, done_next, step_down_next;
  logic             timer_load, timer_clear, timer_expire;
  logic [CNT_W-1:0] pmin_eff, pstart_eff, left_dec, cur_dn, cur_up;
  logic [31:0]      dn_wide, up_wide;

  assign pmin_eff   = (per_min < LIM) ? LIM : per_min;
  assign pstart_eff = (per_start < pmin_eff) ? pmin_eff : per_start;
  assign left_dec   = steps_left - ONE;

  // Ramp arithmetic runs wide so neither direction can wrap before clamping.
  assign dn_wide = sat_addsub(32'(cur_per_reg), 32'(per_dec_reg), 1'b1);
  assign up_wide = sat_addsub(32'(cur_per_reg), 32'(per_dec_reg), 1'b0);
  assign cur_dn  = (dn_wide < 32'(per_min_reg))   ? per_min_reg   : dn_wide[CNT_W-1:0];
  assign cur_up  = (up_wide > 32'(per_start_reg)) ? per_start_reg : up_wide[CNT_W-1:0];

  always_comb begin
    state_next      = state_reg;
    cur_per_next    = cur_per_reg;
    ramp_cnt_next   = ramp_cnt_reg;
    per_start_next  = per_start_reg;
    per_min_next    = per_min_reg;
    per_dec_next    = per_dec_reg;
    steps_left_next = steps_left;
    busy_next       = busy;
    done_next       = 1'b0;
    step_down_next  = step_down;
    timer_load      = 1'b0;
    timer_clear     = 1'b0;

    if (state_reg == IDLE) begin
      // done blocks a start in the same cycle so back-to-back moves get a gap.
      if (start && !done) begin
        if (steps != '0) begin
          state_next      = ACCEL;
          busy_next       = 1'b1;
          step_down_next  = dir;
          steps_left_next = steps;
          ramp_cnt_next   = '0;
          per_start_next  = pstart_eff;
          per_min_next    = pmin_eff;
          per_dec_next    = per_dec;
          cur_per_next    = pstart_eff;
          timer_load      = 1'b1;
        end else begin
          done_next = 1'b1;
        end
      end
    end else if (timer_expire) begin
      if (left_dec == '0) begin
        state_next      = IDLE;
        busy_next       = 1'b0;
        done_next       = 1'b1;
        steps_left_next = '0;
        ramp_cnt_next   = '0;
        timer_clear     = 1'b1;
      end else begin
        steps_left_next = left_dec;
        timer_load      = 1'b1;
        // Compare against the pre-step ramp count so the profile stays symmetric.
        if ((per_dec_reg != '0) &&
            ((state_reg == DECEL) || (left_dec <= ramp_cnt_reg))) begin
          state_next   = DECEL;
          cur_per_next = cur_up;
          if (ramp_cnt_reg != '0) begin
            ramp_cnt_next = ramp_cnt_reg - ONE;
          end
        end else if (state_reg == ACCEL) begin
          cur_per_next  = cur_dn;
          ramp_cnt_next = ramp_cnt_reg + ONE;
          if ((per_dec_reg != '0) && (cur_dn == per_min_reg)) begin
            state_next = CRUISE;
          end
        end
      end
    end

`ifdef STEP_RAMP_ABORT_EN
    if (abort && busy && (state_next != IDLE)) begin
      state_next = DECEL;
      if (ramp_cnt_next < steps_left_next) begin
        steps_left_next = ramp_cnt_next;
      end
      if (steps_left_next == '0) begin
        state_next    = IDLE;
        busy_next     = 1'b0;
        done_next     = 1'b1;
        ramp_cnt_next = '0;
        timer_load    = 1'b0;
        timer_clear   = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cur_per_reg   <= '0;
      ramp_cnt_reg  <= '0;
      per_start_reg <= '0;
      per_min_reg   <= '0;
      per_dec_reg   <= '0;
      steps_left    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      step_down     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cur_per_reg   <= cur_per_next;
      ramp_cnt_reg  <= ramp_cnt_next;
      per_start_reg <= per_start_next;
      per_min_reg   <= per_min_next;
      per_dec_reg   <= per_dec_next;
      steps_left    <= steps_left_next;
      busy          <= busy_next;
      done          <= done_next;
      step_down     <= step_down_next;
    end
  end

  step_period_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .load    (timer_load),
    .load_val(cur_per_next),
    .expire  (timer_expire)
  );

  assign step_ce = timer_expire;

endmodule

// File: tb/tb_step_ramp_gen.sv
// Directed self-checking bench for step_ramp_gen; timings are cycles after the accept cycle.
// The abort scenario runs only when STEP_RAMP_ABORT_EN is defined.
module tb_step_ramp_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        dir = 1'b0;
  logic [15:0] steps = '0;
  logic [15:0] per_start = '0;
  logic [15:0] per_min = '0;
  logic [15:0] per_dec = '0;
`ifdef STEP_RAMP_ABORT_EN
  logic        abort = 1'b0;
`endif
  logic        step_ce, step_down, busy, done;
  logic [15:0] steps_left;

  int checks = 0;
  int failures = 0;

  int st_time[0:255];
  int st_left[0:255];
  int n_st, done_at, n_done, busy_lo, busy_hi, down_bad, done_left;
  bit timed_out;

  step_ramp_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dir       (dir),
    .steps     (steps),
    .per_start (per_start),
    .per_min   (per_min),
    .per_dec   (per_dec),
`ifdef STEP_RAMP_ABORT_EN
    .abort     (abort),
`endif
    .step_ce   (step_ce),
    .step_down (step_down),
    .busy      (busy),
    .done      (done),
    .steps_left(steps_left)
  );

  always #5 clk = ~clk;

  // Issues a start in the current cycle (caller sits at a negedge) and records the move.
  task automatic run_move(input int n, input int ps, input int pm, input int pd,
                          input logic d, input int restart_at, input int abort_at,
                          input int budget);
    int c;
    steps = 16'(n);
    per_start = 16'(ps);
    per_min = 16'(pm);
    per_dec = 16'(pd);
    dir = d;
    start = 1'b1;
    c = 0;
    n_st = 0; n_done = 0; done_at = -1; busy_lo = 0; busy_hi = 0;
    down_bad = 0; done_left = -1; timed_out = 1'b0;
    while (c < budget && n_done == 0) begin
      @(negedge clk);
      c++;
      start = (c == restart_at);
      if (c == restart_at) steps = 16'd1;
`ifdef STEP_RAMP_ABORT_EN
      abort = (c == abort_at);
`else
      if (abort_at >= 0 && c == abort_at) $display("note: abort port not built, request at cycle %0d skipped", c);
`endif
      if (step_ce) begin
        if (n_st < 256) begin
          st_time[n_st] = c;
          st_left[n_st] = int'(steps_left);
        end
        n_st++;
      end
      if (busy) busy_hi++; else busy_lo++;
      if (busy && step_down !== d) down_bad++;
      if (done) begin
        n_done++;
        done_at = c;
        done_left = int'(steps_left);
      end
    end
    start = 1'b0;
`ifdef STEP_RAMP_ABORT_EN
    abort = 1'b0;
`endif
    if (n_done == 0) timed_out = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({step_ce, step_down, busy, done} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 0000", {step_ce, step_down, busy, done});
    end
    checks++;
    if (steps_left !== 16'd0) begin
      failures++;
      $display("FAIL reset_steps_left: got %0d expected 0", steps_left);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({step_ce, busy, done} !== 3'b000) begin
      failures++;
      $display("FAIL idle_after_reset: got %b expected 000", {step_ce, busy, done});
    end
    $display("test_reset done");
  endtask

  task automatic test_constant_rate();
    int exp_t[4] = '{5, 10, 15, 20};
    int exp_l[4] = '{4, 3, 2, 1};
    run_move(4, 5, 5, 0, 1'b0, -1, -1, 200);
    checks++;
    if (timed_out || n_st != 4) begin
      failures++;
      $display("FAIL const_count: got %0d steps (timeout=%0d) expected 4", n_st, timed_out);
    end
    for (int i = 0; i < 4; i++) begin
      if (i < n_st) begin
        checks++;
        if (st_time[i] != exp_t[i] || st_left[i] != exp_l[i]) begin
          failures++;
          $display("FAIL const_step%0d: got t=%0d left=%0d expected t=%0d left=%0d",
                   i, st_time[i], st_left[i], exp_t[i], exp_l[i]);
        end
      end
    end
    checks++;
    if (done_at != 21 || done_left != 0) begin
      failures++;
      $display("FAIL const_done: got t=%0d left=%0d expected t=21 left=0", done_at, done_left);
    end
    $display("test_constant_rate: steps=%0d done_at=%0d", n_st, done_at);
  endtask

  task automatic test_ramp();
    int exp_t[10] = '{8, 14, 18, 22, 26, 30, 34, 38, 44, 52};
    @(negedge clk);
    run_move(10, 8, 4, 2, 1'b0, -1, -1, 300);
    checks++;
    if (timed_out || n_st != 10) begin
      failures++;
      $display("FAIL ramp_count: got %0d steps (timeout=%0d) expected 10", n_st, timed_out);
    end
    for (int i = 0; i < 10; i++) begin
      if (i < n_st) begin
        checks++;
        if (st_time[i] != exp_t[i]) begin
          failures++;
          $display("FAIL ramp_step%0d: got t=%0d expected t=%0d", i, st_time[i], exp_t[i]);
        end
      end
    end
    checks++;
    if (done_at != 53 || busy_lo != 1) begin
      failures++;
      $display("FAIL ramp_done_busy: got done=%0d busy_low_cycles=%0d expected done=53 busy_low_cycles=1",
               done_at, busy_lo);
    end
    $display("test_ramp: steps=%0d done_at=%0d", n_st, done_at);
  endtask

  task automatic test_short_move();
    int exp_t[3] = '{10, 17, 27};
    @(negedge clk);
    run_move(3, 10, 2, 3, 1'b1, -1, -1, 200);
    checks++;
    if (timed_out || n_st != 3) begin
      failures++;
      $display("FAIL short_count: got %0d steps (timeout=%0d) expected 3", n_st, timed_out);
    end
    for (int i = 0; i < 3; i++) begin
      if (i < n_st) begin
        checks++;
        if (st_time[i] != exp_t[i]) begin
          failures++;
          $display("FAIL short_step%0d: got t=%0d expected t=%0d", i, st_time[i], exp_t[i]);
        end
      end
    end
    checks++;
    if (down_bad != 0 || done_at != 28) begin
      failures++;
      $display("FAIL short_dir_done: got bad_dir_cycles=%0d done=%0d expected 0 and 28", down_bad, done_at);
    end
    $display("test_short_move: steps=%0d done_at=%0d", n_st, done_at);
  endtask

  task automatic test_zero_steps();
    @(negedge clk);
    run_move(0, 5, 5, 0, 1'b0, -1, -1, 20);
    checks++;
    if (timed_out || n_st != 0 || done_at != 1 || busy_hi != 0) begin
      failures++;
      $display("FAIL zero_steps: got steps=%0d done=%0d busy_cycles=%0d expected 0, 1, 0",
               n_st, done_at, busy_hi);
    end
    repeat (5) @(negedge clk) begin
      checks++;
      if (done !== 1'b0) begin
        failures++;
        $display("FAIL zero_single_done: got done=%b expected 0", done);
      end
    end
    $display("test_zero_steps: done_at=%0d", done_at);
  endtask

  task automatic test_clamp();
    @(negedge clk);
    run_move(2, 0, 0, 0, 1'b0, -1, -1, 100);
    checks++;
    if (timed_out || n_st != 2 || st_time[0] != 2 || st_time[1] != 4 || done_at != 5) begin
      failures++;
      $display("FAIL clamp: got steps=%0d t0=%0d t1=%0d done=%0d expected 2, 2, 4, 5",
               n_st, st_time[0], st_time[1], done_at);
    end
    $display("test_clamp: steps=%0d done_at=%0d", n_st, done_at);
  endtask

  task automatic test_start_while_busy();
    int extra;
    @(negedge clk);
    run_move(4, 5, 5, 0, 1'b0, 3, -1, 200);
    checks++;
    if (timed_out || n_st != 4 || st_time[3] != 20 || done_at != 21) begin
      failures++;
      $display("FAIL busy_start: got steps=%0d last=%0d done=%0d expected 4, 20, 21",
               n_st, st_time[3], done_at);
    end
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (step_ce || done || busy) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL busy_start_residue: got %0d active cycles expected 0", extra);
    end
    $display("test_start_while_busy: steps=%0d done_at=%0d", n_st, done_at);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    run_move(1, 3, 3, 0, 1'b0, -1, -1, 50);
    // still in the done cycle: this start must be dropped
    steps = 16'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL start_in_done_cycle: got busy=%b expected 0", busy);
    end
    run_move(2, 3, 3, 0, 1'b1, -1, -1, 50);
    checks++;
    if (timed_out || n_st != 2 || st_time[0] != 3 || st_time[1] != 6 || done_at != 7) begin
      failures++;
      $display("FAIL back_to_back: got steps=%0d t0=%0d t1=%0d done=%0d expected 2, 3, 6, 7",
               n_st, st_time[0], st_time[1], done_at);
    end
    $display("test_back_to_back: steps=%0d done_at=%0d", n_st, done_at);
  endtask

  task automatic test_reset_mid_move();
    int c, seen, after;
    @(negedge clk);
    steps = 16'd10; per_start = 16'd8; per_min = 16'd4; per_dec = 16'd2;
    dir = 1'b1;
    start = 1'b1;
    c = 0; seen = 0;
    while (seen < 3 && c < 200) begin
      @(negedge clk);
      c++;
      start = 1'b0;
      if (step_ce) seen++;
    end
    checks++;
    if (seen != 3) begin
      failures++;
      $display("FAIL midreset_reach: got %0d steps expected 3", seen);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({step_ce, step_down, busy, done} !== 4'b0000 || steps_left !== 16'd0) begin
      failures++;
      $display("FAIL midreset_clear: got flags=%b left=%0d expected 0000 and 0",
               {step_ce, step_down, busy, done}, steps_left);
    end
    @(negedge clk);
    rst_n = 1'b1;
    after = 0;
    repeat (100) begin
      @(negedge clk);
      if (step_ce || done || busy) after++;
    end
    checks++;
    if (after != 0) begin
      failures++;
      $display("FAIL midreset_abandon: got %0d active cycles expected 0", after);
    end
    $display("test_reset_mid_move: steps_before_reset=%0d", seen);
  endtask

`ifdef STEP_RAMP_ABORT_EN
  task automatic test_abort();
    int exp_t[6] = '{10, 18, 24, 28, 34, 42};
    @(negedge clk);
    run_move(100, 10, 4, 2, 1'b0, -1, 26, 400);
    checks++;
    if (timed_out || n_st != 6 || done_at != 43) begin
      failures++;
      $display("FAIL abort_count: got steps=%0d done=%0d expected 6 and 43", n_st, done_at);
    end
    for (int i = 0; i < 6; i++) begin
      if (i < n_st) begin
        checks++;
        if (st_time[i] != exp_t[i]) begin
          failures++;
          $display("FAIL abort_step%0d: got t=%0d expected t=%0d", i, st_time[i], exp_t[i]);
        end
      end
    end
    if (n_st > 3) begin
      checks++;
      if (st_left[3] != 3) begin
        failures++;
        $display("FAIL abort_left: got %0d expected 3", st_left[3]);
      end
    end
    $display("test_abort: steps=%0d done_at=%0d", n_st, done_at);
  endtask
`endif

  initial begin
    test_reset();
    test_constant_rate();
    test_ramp();
    test_short_move();
    test_zero_steps();
    test_clamp();
    test_start_while_busy();
    test_back_to_back();
`ifdef STEP_RAMP_ABORT_EN
    test_abort();
`endif
    test_reset_mid_move();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
